// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    localparam int MD_CNT_W       = 4;
    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/muldiv_arith.sv
// Combinational 32x32 multiply and divide producing the 64-bit HI/LO result.
module muldiv_arith
    import muldiv_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div_zero
);

    logic        w_is_div;
    logic        w_sdiv;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_q_raw;
    logic [31:0] w_r_raw;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_smul;
    logic [63:0] w_umul;

    assign w_is_div   = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_sdiv     = (i_op == OP_DIV);
    assign o_div_zero = w_is_div && (i_b == 32'd0);

    assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_umul = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide runs on magnitudes so INT_MIN / -1 cannot overflow.
    assign w_a_mag = i_a[31] ? (~i_a + 32'd1) : i_a;
    assign w_b_mag = i_b[31] ? (~i_b + 32'd1) : i_b;
    assign w_dvd   = w_sdiv ? w_a_mag : i_a;
    assign w_dvs   = (i_b == 32'd0) ? 32'd1 : (w_sdiv ? w_b_mag : i_b);
    assign w_q_raw = w_dvd / w_dvs;
    assign w_r_raw = w_dvd % w_dvs;

    assign w_quo = (w_sdiv && (i_a[31] ^ i_b[31])) ? (~w_q_raw + 32'd1) : w_q_raw;
    assign w_rem = (w_sdiv && i_a[31]) ? (~w_r_raw + 32'd1) : w_r_raw;

    always_comb begin
        o_res_hi = 32'd0;
        o_res_lo = 32'd0;
        case (i_op)
            OP_MULT: begin
                o_res_hi = w_smul[63:32];
                o_res_lo = w_smul[31:0];
            end
            OP_MULTU: begin
                o_res_hi = w_umul[63:32];
                o_res_lo = w_umul[31:0];
            end
            OP_DIV, OP_DIVU: begin
                o_res_hi = w_rem;
                o_res_lo = w_quo;
            end
            default: begin
                o_res_hi = 32'd0;
                o_res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner beside the E-stage ALU: latches mul/div results and
// models fixed latency with a busy counter, requesting stalls meanwhile.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [MD_CNT_W-1:0] LP_MUL = MD_CNT_W'(MUL_CYCLES);
    localparam logic [MD_CNT_W-1:0] LP_DIV = MD_CNT_W'(DIV_CYCLES);

    md_state_t           r_state, w_state_nxt;
    logic [MD_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]         r_pend_hi, w_pend_hi_nxt;
    logic [31:0]         r_pend_lo, w_pend_lo_nxt;
    logic                r_pend_dz, w_pend_dz_nxt;
    logic [31:0]         r_hi, w_hi_nxt;
    logic [31:0]         r_lo, w_lo_nxt;

    logic        w_is_md;
    logic        w_is_div;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_div_zero;

    muldiv_arith u_arith (
        .i_op       (op),
        .i_a        (a),
        .i_b        (b),
        .o_res_hi   (w_res_hi),
        .o_res_lo   (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    assign w_is_md  = (op <= 3'd3);
    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);

    assign busy      = (r_state == ST_RUN);
    assign stall_req = md_use & (busy | (start & w_is_md));
    assign hi        = r_hi;
    assign lo        = r_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_dz <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_dz <= w_pend_dz_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_dz_nxt = r_pend_dz;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_md) begin
                        w_pend_hi_nxt = w_res_hi;
                        w_pend_lo_nxt = w_res_lo;
                        w_pend_dz_nxt = w_div_zero;
                        w_cnt_nxt     = w_is_div ? LP_DIV : LP_MUL;
                        w_state_nxt   = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        w_hi_nxt = a;
                    end else if (op == OP_MTLO) begin
                        w_lo_nxt = a;
                    end
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - 1'b1;
                // Divide-by-zero still burns the full latency but leaves HI/LO alone.
                if (r_cnt <= 1) begin
                    if (!r_pend_dz) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised self-checking bench for muldiv_ctrl against an arithmetic model.
module tb_muldiv_ctrl;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    muldiv_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .md_use    (md_use),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic ref_calc(input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, output logic [63:0] r,
                            output logic z);
        longint sx, sy, q, m;
        longint unsigned ux, uy, uq, um;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r = 64'd0;
        z = 1'b0;
        case (o)
            3'd0: r = sx * sy;
            3'd1: r = ux * uy;
            3'd2: begin
                if (y == 32'd0) z = 1'b1;
                else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (y == 32'd0) z = 1'b1;
                else begin
                    uq = ux / uy;
                    um = ux % uy;
                    r = {um[31:0], uq[31:0]};
                end
            end
            default: r = 64'd0;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        op = 3'd0;
        a = 32'd0;
        b = 32'd0;
        md_use = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL reset busy=%b hi=%h lo=%h stall=%b want 0/0/0/0",
                     busy, hi, lo, stall_req);
        end
        rst = 1'b1;
        @(negedge clk);
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [31:0] x);
        start = 1'b1;
        op = o;
        a = x;
        md_use = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL mt_stall op=%0d got %b want 0", o, stall_req);
        end
        @(negedge clk);
        start = 1'b0;
        if (o == 3'd4) mdl_hi = x;
        else mdl_lo = x;
        checks++;
        if (hi !== mdl_hi || lo !== mdl_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL mt_write op=%0d hi=%h lo=%h busy=%b want %h %h 0",
                     o, hi, lo, busy, mdl_hi, mdl_lo);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic mu);
        logic [63:0] r;
        logic z;
        int n, nexp;
        logic [31:0] old_hi, old_lo;
        ref_calc(o, x, y, r, z);
        nexp = (o <= 3'd1) ? MUL_N : DIV_N;
        old_hi = mdl_hi;
        old_lo = mdl_lo;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        md_use = mu;
        #1;
        checks++;
        if (stall_req !== mu) begin
            errors++;
            $display("FAIL issue_stall op=%0d got %b want %b", o, stall_req, mu);
        end
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            checks++;
            if (stall_req !== mu || hi !== old_hi || lo !== old_lo) begin
                errors++;
                $display("FAIL busy_hold cyc=%0d stall=%b hi=%h lo=%h want %b %h %h",
                         n, stall_req, hi, lo, mu, old_hi, old_lo);
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != nexp) begin
            errors++;
            $display("FAIL busy_len op=%0d got %0d want %0d", o, n, nexp);
        end
        if (!z) begin
            mdl_hi = r[63:32];
            mdl_lo = r[31:0];
        end
        checks++;
        if (hi !== mdl_hi || lo !== mdl_lo) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h hi=%h lo=%h want %h %h",
                     o, x, y, hi, lo, mdl_hi, mdl_lo);
        end
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_stall got %b want 0", stall_req);
        end
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'hFFFFFFFF, 32'd2, 1'b1);
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b1);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_op(3'd3, 32'hFFFFFFF9, 32'd7, 1'b1);
    endtask

    task automatic test_divzero();
        do_mt(3'd4, 32'h11);
        do_mt(3'd5, 32'h22);
        run_op(3'd3, $urandom, 32'd0, 1'b1);
        run_op(3'd2, $urandom, 32'd0, 1'b0);
    endtask

    task automatic test_stall_ignore();
        logic [63:0] r;
        logic z;
        logic [31:0] x, y;
        int n;
        x = $urandom;
        y = $urandom;
        ref_calc(3'd0, x, y, r, z);
        start = 1'b1;
        op = 3'd0;
        a = x;
        b = y;
        md_use = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 1) begin
                start = 1'b1;
                op = 3'd2;
                a = $urandom;
                b = $urandom | 32'd1;
            end else begin
                start = 1'b0;
            end
            #1;
            checks++;
            if (stall_req !== 1'b1) begin
                errors++;
                $display("FAIL ign_stall cyc=%0d got %b want 1", n, stall_req);
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        mdl_hi = r[63:32];
        mdl_lo = r[31:0];
        checks++;
        if (n != MUL_N || hi !== mdl_hi || lo !== mdl_lo) begin
            errors++;
            $display("FAIL ign_result len=%0d hi=%h lo=%h want %0d %h %h",
                     n, hi, lo, MUL_N, mdl_hi, mdl_lo);
        end
        for (int i = 0; i < DIV_N + 2; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || hi !== mdl_hi || lo !== mdl_lo) begin
                errors++;
                $display("FAIL ign_late cyc=%0d busy=%b hi=%h lo=%h want 0 %h %h",
                         i, busy, hi, lo, mdl_hi, mdl_lo);
            end
        end
    endtask

    task automatic test_reserved();
        for (int k = 6; k < 8; k++) begin
            start = 1'b1;
            op = 3'(k);
            a = $urandom;
            md_use = 1'b1;
            #1;
            checks++;
            if (stall_req !== 1'b0) begin
                errors++;
                $display("FAIL rsv_stall op=%0d got %b want 0", k, stall_req);
            end
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (busy !== 1'b0 || hi !== mdl_hi || lo !== mdl_lo) begin
                errors++;
                $display("FAIL rsv_nop op=%0d busy=%b hi=%h lo=%h want 0 %h %h",
                         k, busy, hi, lo, mdl_hi, mdl_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] o;
        logic [31:0] y;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) y = 32'hFFFFFFFF;
            run_op(o, $urandom, y, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        do_mt(3'd4, $urandom | 32'h1);
        do_mt(3'd5, $urandom | 32'h1);
        start = 1'b1;
        op = 3'd2;
        a = 32'd1000;
        b = 32'd7;
        md_use = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset busy=%b hi=%h lo=%h stall=%b want 0 0 0 0",
                     busy, hi, lo, stall_req);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DIV_N + 2; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                errors++;
                $display("FAIL no_commit cyc=%0d busy=%b hi=%h lo=%h want 0 0 0",
                         i, busy, hi, lo);
            end
        end
    endtask

    initial begin
        test_reset();
        do_mt(3'd4, $urandom);
        do_mt(3'd5, $urandom);
        test_directed();
        test_divzero();
        test_stall_ignore();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
